ahb_slave_mem: RTL and testbench

AHB_SLAVE_MEM -- requirements
Module: ahb_slave_mem

---
 rtl/ahb_slave_mem.sv | 131 +++++++++++++
 tb/tb_ahb_slave_mem.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_slave_mem.sv
// AHB-Lite slave backed by a word-organised memory, with optional wait states.
// Define AHB_SLAVE_MEM_ERR_EN to get ERROR responses for out-of-range or misaligned accesses.
module ahb_slave_mem #(
    parameter int mem_depth = 256,
    parameter int wait_c    = 0
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic [31:0] haddr,
    input  logic [31:0] hwdata,
    output logic [31:0] hrdata,
    input  logic        hwrite,
    input  logic [1:0]  htrans,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    output logic [1:0]  hresp,
    output logic        hready,
    input  logic        hsel
);

    localparam int idx_w = $clog2(mem_depth);

    localparam logic [1:0] st_idle = 2'd0;
    localparam logic [1:0] st_wait = 2'd1;
    localparam logic [1:0] st_err1 = 2'd2;
    localparam logic [1:0] st_err2 = 2'd3;

    logic [31:0]      mem [mem_depth];

    logic [1:0]       state;
    logic [3:0]       wcnt;
    logic             dp_valid;
    logic             dp_write;
    logic [idx_w-1:0] dp_idx;
    logic [1:0]       dp_size;
    logic [1:0]       dp_lo;

    logic             start;
    logic             addr_err;
    logic [1:0]       size_in;
    logic [1:0]       lo_in;
    logic [3:0]       be;
    logic             commit;
    logic             unused_bits;

    assign hready = (state == st_idle) || (state == st_err2);
    assign start  = hsel && htrans[1] && hready;
    assign commit = dp_valid && dp_write && hready;
    assign hrdata = (dp_valid && !dp_write) ? mem[dp_idx] : 32'h0;

    // Oversized transfers collapse to word; the low address bits are forced to the transfer alignment.
    assign size_in = (hsize > 3'd2) ? 2'd2 : hsize[1:0];
    assign lo_in   = (size_in == 2'd0) ? haddr[1:0] :
                     (size_in == 2'd1) ? {haddr[1], 1'b0} : 2'b00;

`ifdef AHB_SLAVE_MEM_ERR_EN
    assign addr_err = (haddr[31:idx_w+2] != '0)
                   || (hsize > 3'd2)
                   || ((hsize == 3'd1) && haddr[0])
                   || ((hsize == 3'd2) && (haddr[1:0] != 2'b00));
    assign hresp    = ((state == st_err1) || (state == st_err2)) ? 2'b01 : 2'b00;
    assign unused_bits = ^{hburst, htrans[0]};
`else
    assign addr_err = 1'b0;
    assign hresp    = 2'b00;
    assign unused_bits = ^{hburst, htrans[0], haddr[31:idx_w+2]};
`endif

    always_comb begin
        be = 4'b0000;
        case (dp_size)
            2'd0:    be = 4'b0001 << dp_lo;
            2'd1:    be = dp_lo[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state    <= st_idle;
            wcnt     <= '0;
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_idx   <= '0;
            dp_size  <= '0;
            dp_lo    <= '0;
        end else begin
            case (state)
                st_idle, st_err2: begin
                    if (start) begin
                        if (addr_err) begin
                            state    <= st_err1;
                            dp_valid <= 1'b0;
                        end else begin
                            dp_valid <= 1'b1;
                            dp_write <= hwrite;
                            dp_idx   <= haddr[idx_w+1:2];
                            dp_size  <= size_in;
                            dp_lo    <= lo_in;
                            if (wait_c > 0) begin
                                state <= st_wait;
                                wcnt  <= 4'(wait_c - 1);
                            end else begin
                                state <= st_idle;
                            end
                        end
                    end else begin
                        state    <= st_idle;
                        dp_valid <= 1'b0;
                    end
                end
                st_wait: begin
                    if (wcnt == 4'd0) state <= st_idle;
                    else              wcnt  <= wcnt - 4'd1;
                end
                st_err1: state <= st_err2;
                default: state <= st_idle;
            endcase
        end
    end

    // Memory has no reset; an in-flight write is dropped because reset clears dp_valid.
    always_ff @(posedge hclk) begin
        if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[dp_idx][8*b +: 8] <= hwdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Directed bench for ahb_slave_mem: one zero-wait instance and one three-wait instance on a shared bus.
module tb_ahb_slave_mem;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic        hwrite;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic        hsel0;
    logic        hsel3;
    logic [31:0] hrdata0, hrdata3;
    logic [1:0]  hresp0, hresp3;
    logic        hready0, hready3;

    logic        which;
    logic        cur_hready;
    logic [31:0] cur_hrdata;
    logic [1:0]  cur_hresp;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] rd;
    logic [1:0]  rs;
    int          lw;

    assign cur_hready = which ? hready3 : hready0;
    assign cur_hrdata = which ? hrdata3 : hrdata0;
    assign cur_hresp  = which ? hresp3  : hresp0;

    always #5 hclk = ~hclk;

    ahb_slave_mem #(.mem_depth(256), .wait_c(0)) dut0 (
        .hclk(hclk), .hresetn(hresetn), .haddr(haddr), .hwdata(hwdata), .hrdata(hrdata0),
        .hwrite(hwrite), .htrans(htrans), .hsize(hsize), .hburst(hburst),
        .hresp(hresp0), .hready(hready0), .hsel(hsel0)
    );

    ahb_slave_mem #(.mem_depth(256), .wait_c(3)) dut3 (
        .hclk(hclk), .hresetn(hresetn), .haddr(haddr), .hwdata(hwdata), .hrdata(hrdata3),
        .hwrite(hwrite), .htrans(htrans), .hsize(hsize), .hburst(hburst),
        .hresp(hresp3), .hready(hready3), .hsel(hsel3)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // One non-pipelined transfer; starts and ends 1 time unit after a rising edge.
    task automatic applyStimulus(input logic sel3, input logic wr, input logic [31:0] addr,
                                 input logic [2:0] size, input logic [31:0] wdata,
                                 output logic [31:0] rdata, output logic [1:0] resp, output int low);
        logic done;
        which  = sel3;
        haddr  = addr;
        hwrite = wr;
        hsize  = size;
        htrans = 2'b10;
        hsel0  = !sel3;
        hsel3  = sel3;
        @(posedge hclk); #1;
        htrans = 2'b00;
        hsel0  = 1'b0;
        hsel3  = 1'b0;
        hwdata = wdata;
        low    = 0;
        done   = 1'b0;
        rdata  = '0;
        resp   = '0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge hclk);
            if (cur_hready) begin
                rdata = cur_hrdata;
                resp  = cur_hresp;
                done  = 1'b1;
            end else begin
                low++;
            end
            @(posedge hclk); #1;
        end
        if (!done) checkOutput("xfer_timeout", {31'b0, cur_hready}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        hresetn = 1'b0;
        haddr   = '0;
        hwdata  = '0;
        hwrite  = 1'b0;
        htrans  = 2'b00;
        hsize   = 3'd2;
        hburst  = 3'd0;
        hsel0   = 1'b0;
        hsel3   = 1'b0;
        which   = 1'b0;

        repeat (2) @(posedge hclk);
        @(negedge hclk);
        checkOutput("rst_hready0", {31'b0, hready0}, 32'd1);
        checkOutput("rst_hresp0",  {30'b0, hresp0},  32'd0);
        checkOutput("rst_hrdata0", hrdata0,          32'd0);
        checkOutput("rst_hready3", {31'b0, hready3}, 32'd1);
        checkOutput("rst_hresp3",  {30'b0, hresp3},  32'd0);
        checkOutput("rst_hrdata3", hrdata3,          32'd0);
        @(posedge hclk); #1;
        hresetn = 1'b1;
        @(posedge hclk); #1;

        // Zero-wait word write then read
        applyStimulus(1'b0, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF, rd, rs, lw);
        checkOutput("w0_low", lw, 0);
        checkOutput("w0_hrdata_wr", rd, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h10, 3'd2, 32'h0, rd, rs, lw);
        checkOutput("r0_low", lw, 0);
        checkOutput("r0_data", rd, 32'hDEADBEEF);
        checkOutput("r0_resp", {30'b0, rs}, 32'd0);

        // Three-wait write and read
        applyStimulus(1'b1, 1'b1, 32'h20, 3'd2, 32'hCAFEF00D, rd, rs, lw);
        checkOutput("w3_low", lw, 3);
        applyStimulus(1'b1, 1'b0, 32'h20, 3'd2, 32'h0, rd, rs, lw);
        checkOutput("r3_low", lw, 3);
        checkOutput("r3_data", rd, 32'hCAFEF00D);

        // Byte and halfword lanes
        applyStimulus(1'b0, 1'b1, 32'h0, 3'd2, 32'h00000000, rd, rs, lw);
        applyStimulus(1'b0, 1'b1, 32'h2, 3'd0, 32'h00AB0000, rd, rs, lw);
        applyStimulus(1'b0, 1'b1, 32'h0, 3'd1, 32'h00001234, rd, rs, lw);
        applyStimulus(1'b0, 1'b0, 32'h0, 3'd2, 32'h0, rd, rs, lw);
        checkOutput("lanes_a", rd, 32'h00AB1234);
        applyStimulus(1'b0, 1'b1, 32'h3, 3'd0, 32'h77000000, rd, rs, lw);
        applyStimulus(1'b0, 1'b0, 32'h0, 3'd2, 32'h0, rd, rs, lw);
        checkOutput("lanes_b", rd, 32'h77AB1234);
        applyStimulus(1'b0, 1'b1, 32'h4, 3'd2, 32'h11111111, rd, rs, lw);
        applyStimulus(1'b0, 1'b1, 32'h6, 3'd1, 32'hBEEF0000, rd, rs, lw);
        applyStimulus(1'b0, 1'b0, 32'h4, 3'd2, 32'h0, rd, rs, lw);
        checkOutput("lanes_hi_half", rd, 32'hBEEF1111);

        // Out-of-range word write
        applyStimulus(1'b0, 1'b1, 32'h400, 3'd2, 32'h0BADF00D, rd, rs, lw);
`ifdef AHB_SLAVE_MEM_ERR_EN
        checkOutput("oor_low", lw, 1);
        checkOutput("oor_resp", {30'b0, rs}, 32'd1);
        applyStimulus(1'b0, 1'b0, 32'h0, 3'd2, 32'h0, rd, rs, lw);
        checkOutput("oor_mem", rd, 32'h77AB1234);
`else
        checkOutput("oor_low", lw, 0);
        checkOutput("oor_resp", {30'b0, rs}, 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 3'd2, 32'h0, rd, rs, lw);
        checkOutput("oor_wrap", rd, 32'h0BADF00D);
`endif

        // Deselected NONSEQ, then selected BUSY: neither is a transfer
        which  = 1'b0;
        haddr  = 32'h10;
        hwrite = 1'b1;
        hsize  = 3'd2;
        htrans = 2'b10;
        hsel0  = 1'b0;
        @(posedge hclk); #1;
        hwdata = 32'h0;
        htrans = 2'b01;
        hsel0  = 1'b1;
        @(negedge hclk);
        checkOutput("nosel_hready", {31'b0, hready0}, 32'd1);
        @(posedge hclk); #1;
        htrans = 2'b00;
        hsel0  = 1'b0;
        @(negedge hclk);
        checkOutput("busy_hready", {31'b0, hready0}, 32'd1);
        @(posedge hclk); #1;
        applyStimulus(1'b0, 1'b0, 32'h10, 3'd2, 32'h0, rd, rs, lw);
        checkOutput("nosel_mem", rd, 32'hDEADBEEF);

        // Write immediately followed by a pipelined read of the same word
        which  = 1'b0;
        haddr  = 32'h8;
        hwrite = 1'b1;
        hsize  = 3'd2;
        htrans = 2'b10;
        hsel0  = 1'b1;
        @(posedge hclk); #1;
        hwdata = 32'h00000055;
        hwrite = 1'b0;
        @(negedge hclk);
        checkOutput("pipe_wr_hrdata", hrdata0, 32'h0);
        @(posedge hclk); #1;
        htrans = 2'b00;
        hsel0  = 1'b0;
        @(negedge hclk);
        checkOutput("pipe_hready", {31'b0, hready0}, 32'd1);
        checkOutput("pipe_data", hrdata0, 32'h00000055);
        @(posedge hclk); #1;
        @(negedge hclk);
        checkOutput("idle_hrdata", hrdata0, 32'h0);
        @(posedge hclk); #1;

        // Reset in the second wait cycle of a wait_c=3 write
        applyStimulus(1'b1, 1'b1, 32'h30, 3'd2, 32'h12345678, rd, rs, lw);
        which  = 1'b1;
        haddr  = 32'h30;
        hwrite = 1'b1;
        hsize  = 3'd2;
        htrans = 2'b10;
        hsel3  = 1'b1;
        @(posedge hclk); #1;
        htrans = 2'b00;
        hsel3  = 1'b0;
        hwdata = 32'hFFFFFFFF;
        @(negedge hclk);
        checkOutput("rw_wait1_hready", {31'b0, hready3}, 32'd0);
        @(posedge hclk); #1;
        checkOutput("rw_wait2_hready", {31'b0, hready3}, 32'd0);
        hresetn = 1'b0;
        #1;
        checkOutput("rw_rst_hready", {31'b0, hready3}, 32'd1);
        checkOutput("rw_rst_hresp", {30'b0, hresp3}, 32'd0);
        checkOutput("rw_rst_hrdata", hrdata3, 32'd0);
        #1;
        hresetn = 1'b1;
        @(posedge hclk); #1;
        applyStimulus(1'b1, 1'b0, 32'h30, 3'd2, 32'h0, rd, rs, lw);
        checkOutput("rw_after_low", lw, 3);
        checkOutput("rw_after_data", rd, 32'h12345678);
        applyStimulus(1'b0, 1'b0, 32'h10, 3'd2, 32'h0, rd, rs, lw);
        checkOutput("rw_mem_kept", rd, 32'hDEADBEEF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
